// File: rtl/key_conditioner_pkg.sv
// key_conditioner_pkg: shared repeat-FSM state, 720p timing defaults and a counter-width helper.
package key_conditioner_pkg;
  typedef enum logic [1:0] {RELEASED, HELD, REPEATING} rep_state_e;
  localparam int PIX_CLK_HZ = 74_250_000;
  localparam int DEB_CYCLES_720P = PIX_CLK_HZ / 50;
  localparam int REPEAT_DELAY_720P = PIX_CLK_HZ / 2;
  localparam int REPEAT_PERIOD_720P = PIX_CLK_HZ / 10;
  function automatic int cnt_width(int v);
    return $clog2(v < 2 ? 2 : v);
  endfunction
endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel - 2-flop synchroniser, debounce, press/release pulses and auto-repeat FSM.
module key_debounce_ch
  import key_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_720P,
  parameter int REPEAT_DELAY = REPEAT_DELAY_720P,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_720P,
  parameter bit KEY_ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic Rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_repeat,
  output logic press_nxt
);
  localparam int DW = cnt_width(DEB_CYCLES);
  localparam int HW = cnt_width(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] DEL_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PER_LAST = HW'(REPEAT_PERIOD - 1);
  logic s1_q, s2_q, level_q, level_d, press_q, press_d, rel_q, rel_d, rep_q, rep_d;
  logic sample, flip;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  rep_state_e st_q, st_d;
  always_comb begin
    sample = s2_q ^ KEY_ACTIVE_LOW;
    flip = (sample != level_q) && (cnt_q == DEB_LAST);
    cnt_d = (sample == level_q || flip) ? '0 : cnt_q + 1'b1;
    level_d = level_q ^ flip;
    press_d = flip & ~level_q;
    rel_d = flip & level_q;
    st_d = st_q;
    hold_d = hold_q + 1'b1;
    rep_d = 1'b0;
    if (rel_d) begin
      st_d = RELEASED;
      hold_d = '0;
    end else if (press_d) begin
      st_d = HELD;
      hold_d = '0;
    end else begin
      case (st_q)
        RELEASED: hold_d = '0;
        HELD: begin
          // a zero delay parks the channel in HELD with the counter idle
          if (REPEAT_DELAY == 0) hold_d = '0;
          else if (hold_q == DEL_LAST) begin
            rep_d = 1'b1;
            hold_d = '0;
            st_d = REPEATING;
          end
        end
        REPEATING: begin
          if (hold_q == PER_LAST) begin
            rep_d = 1'b1;
            hold_d = '0;
          end
        end
        default: begin
          st_d = RELEASED;
          hold_d = '0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      s1_q <= KEY_ACTIVE_LOW;
      s2_q <= KEY_ACTIVE_LOW;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q <= 1'b0;
      rep_q <= 1'b0;
      cnt_q <= '0;
      hold_q <= '0;
      st_q <= RELEASED;
    end else begin
      s1_q <= key_in;
      s2_q <= s1_q;
      level_q <= level_d;
      press_q <= press_d;
      rel_q <= rel_d;
      rep_q <= rep_d;
      cnt_q <= cnt_d;
      hold_q <= hold_d;
      st_q <= st_d;
    end
  end
  assign key_level = level_q;
  assign key_press = press_q;
  assign key_release = rel_q;
  assign key_repeat = rep_q;
  assign press_nxt = press_d;
endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: NUM_KEYS debounced key channels plus a key_any flag registered alongside key_press.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int NUM_KEYS = 2,
  parameter int DEB_CYCLES = DEB_CYCLES_720P,
  parameter int REPEAT_DELAY = REPEAT_DELAY_720P,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_720P,
  parameter bit KEY_ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                Rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic                key_any
);
  logic [NUM_KEYS-1:0] press_nxt;
  logic any_q, any_d;
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
    key_debounce_ch #(
      .DEB_CYCLES(DEB_CYCLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
    ) u_ch (
      .clk(clk),
      .Rst(Rst),
      .key_in(key_in[k]),
      .key_level(key_level[k]),
      .key_press(key_press[k]),
      .key_release(key_release[k]),
      .key_repeat(key_repeat[k]),
      .press_nxt(press_nxt[k])
    );
  end
  // built from the channels' next-press terms so it lands on the same edge as key_press
  always_comb any_d = |press_nxt;
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) any_q <= 1'b0;
    else any_q <= any_d;
  end
  assign key_any = any_q;
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed stimulus pushes expected pulse events; per-DUT monitors pop and compare.
module tb_key_conditioner;
  typedef struct {
    int cyc;
    logic [8:0] v;
  } ev_t;
  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1;
  logic [1:0] key_a = 2'b00, key_b = 2'b11;
  logic [1:0] lvl_a, prs_a, rel_a, rep_a, lvl_b, prs_b, rel_b, rep_b;
  logic any_a, any_b;
  int cyc = 0, passed = 0, total = 0, t;
  ev_t qa[$], qb[$];

  key_conditioner #(.NUM_KEYS(2), .DEB_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5),
                    .KEY_ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .Rst(rst_a), .key_in(key_a), .key_level(lvl_a), .key_press(prs_a),
    .key_release(rel_a), .key_repeat(rep_a), .key_any(any_a));
  key_conditioner #(.NUM_KEYS(2), .DEB_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5),
                    .KEY_ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .Rst(rst_b), .key_in(key_b), .key_level(lvl_b), .key_press(prs_b),
    .key_release(rel_b), .key_repeat(rep_b), .key_any(any_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: actual time limit reached, required finish");
    $fatal(1);
  end

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: actual %h required %h", n, cyc, act, exp);
  endtask

  function automatic logic [8:0] pk(logic [1:0] p, logic [1:0] r, logic [1:0] rp, logic a, logic [1:0] l);
    return {p, r, rp, a, l};
  endfunction

  task automatic push_a(int c, logic [8:0] v);
    qa.push_back('{c, v});
  endtask

  task automatic push_b(int c, logic [8:0] v);
    qb.push_back('{c, v});
  endtask

  task automatic wait_to(int c);
    while (cyc < c) @(negedge clk);
  endtask

  // upper word = edge number, lower word = {press, release, repeat, any, level}
  always @(negedge clk) begin
    ev_t e;
    if ({prs_a, rel_a, rep_a, any_a} != 7'd0) begin
      if (qa.size() == 0) chk("ev_a_unexpected", {32'(cyc), 23'd0, pk(prs_a, rel_a, rep_a, any_a, lvl_a)}, 64'd0);
      else begin
        e = qa.pop_front();
        chk("ev_a", {32'(cyc), 23'd0, pk(prs_a, rel_a, rep_a, any_a, lvl_a)}, {32'(e.cyc), 23'd0, e.v});
      end
    end
  end

  always @(negedge clk) begin
    ev_t e;
    if ({prs_b, rel_b, rep_b, any_b} != 7'd0) begin
      if (qb.size() == 0) chk("ev_b_unexpected", {32'(cyc), 23'd0, pk(prs_b, rel_b, rep_b, any_b, lvl_b)}, 64'd0);
      else begin
        e = qb.pop_front();
        chk("ev_b", {32'(cyc), 23'd0, pk(prs_b, rel_b, rep_b, any_b, lvl_b)}, {32'(e.cyc), 23'd0, e.v});
      end
    end
  end

  initial begin
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    wait_to(3);
    chk("reset_outs_a", 64'({lvl_a, prs_a, rel_a, rep_a, any_a}), 64'd0);
    chk("reset_outs_b", 64'({lvl_b, prs_b, rel_b, rep_b, any_b}), 64'd0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    // clean press then release on key 0
    t = 10;
    wait_to(t);
    key_a = 2'b01;
    push_a(t + 6, pk(2'b01, 2'b00, 2'b00, 1'b1, 2'b01));
    wait_to(t + 5);
    chk("level_before_press", 64'(lvl_a), 64'd0);
    wait_to(t + 7);
    key_a = 2'b00;
    push_a(t + 13, pk(2'b00, 2'b01, 2'b00, 1'b0, 2'b00));
    // bounce: 3 high samples then 3 low, five times
    t = 30;
    for (int i = 0; i < 5; i++) begin
      wait_to(t + 6 * i);
      key_a = 2'b01;
      wait_to(t + 6 * i + 3);
      key_a = 2'b00;
    end
    wait_to(t + 45);
    chk("bounce_level", 64'(lvl_a), 64'd0);
    // auto-repeat on key 1
    t = 80;
    wait_to(t);
    key_a = 2'b10;
    push_a(t + 6, pk(2'b10, 2'b00, 2'b00, 1'b1, 2'b10));
    push_a(t + 16, pk(2'b00, 2'b00, 2'b10, 1'b0, 2'b10));
    push_a(t + 21, pk(2'b00, 2'b00, 2'b10, 1'b0, 2'b10));
    push_a(t + 26, pk(2'b00, 2'b00, 2'b10, 1'b0, 2'b10));
    wait_to(t + 22);
    key_a = 2'b00;
    push_a(t + 28, pk(2'b00, 2'b10, 2'b00, 1'b0, 2'b00));
    wait_to(t + 45);
    chk("repeat_released_level", 64'(lvl_a), 64'd0);
    // simultaneous press on both keys
    t = 140;
    wait_to(t);
    key_a = 2'b11;
    push_a(t + 6, pk(2'b11, 2'b00, 2'b00, 1'b1, 2'b11));
    wait_to(t + 7);
    key_a = 2'b00;
    push_a(t + 13, pk(2'b00, 2'b11, 2'b00, 1'b0, 2'b00));
    // reset while key 0 is held
    t = 170;
    wait_to(t);
    key_a = 2'b01;
    push_a(t + 6, pk(2'b01, 2'b00, 2'b00, 1'b1, 2'b01));
    wait_to(t + 8);
    chk("held_before_reset", 64'(lvl_a), 64'd1);
    rst_a = 1'b0;
    #1;
    chk("reset_mid_outs", 64'({lvl_a, prs_a, rel_a, rep_a, any_a}), 64'd0);
    wait_to(t + 11);
    rst_a = 1'b1;
    push_a(t + 17, pk(2'b01, 2'b00, 2'b00, 1'b1, 2'b01));
    wait_to(t + 18);
    key_a = 2'b00;
    push_a(t + 24, pk(2'b00, 2'b01, 2'b00, 1'b0, 2'b00));
    // active-low build: idle-high pins, then pin 0 low for 6 cycles
    t = 210;
    wait_to(t);
    chk("b_idle_outs", 64'({lvl_b, prs_b, rel_b, rep_b, any_b}), 64'd0);
    key_b = 2'b10;
    push_b(t + 6, pk(2'b01, 2'b00, 2'b00, 1'b1, 2'b01));
    wait_to(t + 6);
    key_b = 2'b11;
    push_b(t + 12, pk(2'b00, 2'b01, 2'b00, 1'b0, 2'b00));
    wait_to(t + 30);
    chk("queue_a_drained", 64'(qa.size()), 64'd0);
    chk("queue_b_drained", 64'(qb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
